// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, SRAM slave state enum and lane helpers.
package ahb_pkg;

    // HTRANS encodings
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // HBURST encodings (informational for this slave)
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;

    // HSIZE encodings supported on a 32-bit bus
    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    // HRESP encodings
    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // SRAM slave data-phase state
    typedef enum logic [2:0] {
        SRAM_IDLE = 3'd0,
        SRAM_WAIT = 3'd1,
        SRAM_DONE = 3'd2,
        SRAM_ERR1 = 3'd3,
        SRAM_ERR2 = 3'd4
    } sram_state_e;

    // Oversized or misaligned transfer for a 32-bit data bus
    function automatic logic size_align_err(input logic [2:0] size, input logic [1:0] addr_lo);
        logic err;
        err = 1'b0;
        if (size > HSIZE_WORD) begin
            err = 1'b1;
        end else if (size == HSIZE_HALF) begin
            err = addr_lo[0];
        end else if (size == HSIZE_WORD) begin
            err = (addr_lo != 2'b00);
        end
        return err;
    endfunction

    // Little-endian byte-lane enables for a legal transfer
    function automatic logic [3:0] lane_enables(input logic [2:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            HSIZE_BYTE: be = 4'b0001 << addr_lo;
            HSIZE_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: be = 4'b1111;
            default:    be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/ahb_sram_byte_mem.sv
// Word-organised SRAM with per-byte write enables and a registered read port.
// Read and write in the same cycle to the same word return the old word;
// the parent merges in the committing write data when that matters.
module ahb_sram_byte_mem #(
    parameter int MEM_DEPTH = 256,
    parameter int AW        = 8
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [MEM_DEPTH];

    // Byte-lane writes; contents are deliberately not reset
    always_ff @(posedge HCLK) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Registered read port, cleared on reset and held between reads
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            rdata <= 32'h0000_0000;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave with programmable wait states, byte-lane writes,
// two-cycle ERROR responses and write-to-read forwarding.
//
// Handshake: an address phase is taken on a rising edge when
// HSEL & HTRANS[1] & HREADYIN (and this slave is ready); its data phase
// completes on the first later rising edge where HREADYOUT=1. Writes commit
// on that completing edge; read data is valid on HRDATA while HREADYOUT=1.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int MEM_DEPTH       = 256,
    parameter int WAIT_STATES     = 0,
    parameter int WAIT_FIRST_ONLY = 0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    input  logic        HREADYIN,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    // FSM and data-phase registers
    sram_state_e   state_q;
    logic          hreadyout_q;
    logic          hresp_q;
    logic [3:0]    wait_cnt_q;
    logic          dp_active_q;
    logic          dp_write_q;
    logic [AW-1:0] dp_idx_q;
    logic [3:0]    dp_be_q;

    // Address-phase decode
    logic          accept;
    logic          acc_err;
    logic          out_of_range;
    logic [3:0]    acc_wait;
    logic [3:0]    acc_be;
    logic [AW-1:0] acc_idx;

    // Memory and forwarding
    logic          mem_we;
    logic          rd_en;
    logic          fwd_hit;
    logic [31:0]   mem_rdata;
    logic [3:0]    fwd_be_q;
    logic [31:0]   fwd_data_q;
    logic [31:0]   rd_word;

    // Burst type carries no meaning here; every beat brings its own address
    logic unused_hburst;
    assign unused_hburst = ^HBURST;

    assign accept       = HSEL & HTRANS[1] & HREADYIN & hreadyout_q;
    assign out_of_range = ({2'b00, HADDR[31:2]} >= 32'(MEM_DEPTH));
    assign acc_idx      = HADDR[AW+1:2];
    assign acc_be       = lane_enables(HSIZE, HADDR[1:0]);

    // Classify the offered transfer and pick its wait count
    always_comb begin
        acc_err  = size_align_err(HSIZE, HADDR[1:0]) | out_of_range;
        acc_wait = 4'(WAIT_STATES);
        if ((WAIT_FIRST_ONLY != 0) && (HTRANS == HTRANS_SEQ)) begin
            acc_wait = 4'd0;
        end
    end

    // Slave FSM with registered HREADYOUT/HRESP; ready states accept like IDLE
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q     <= SRAM_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            wait_cnt_q  <= 4'd0;
            dp_active_q <= 1'b0;
            dp_write_q  <= 1'b0;
            dp_idx_q    <= '0;
            dp_be_q     <= 4'b0000;
        end else begin
            unique case (state_q)
                SRAM_WAIT: begin
                    if (wait_cnt_q <= 4'd1) begin
                        state_q     <= SRAM_DONE;
                        hreadyout_q <= 1'b1;
                        wait_cnt_q  <= 4'd0;
                    end else begin
                        wait_cnt_q  <= wait_cnt_q - 4'd1;
                    end
                end
                SRAM_ERR1: begin
                    state_q     <= SRAM_ERR2;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= HRESP_ERROR;
                end
                default: begin
                    state_q     <= SRAM_IDLE;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= HRESP_OKAY;
                    dp_active_q <= 1'b0;
                    if (accept) begin
                        if (acc_err) begin
                            state_q     <= SRAM_ERR1;
                            hreadyout_q <= 1'b0;
                            hresp_q     <= HRESP_ERROR;
                        end else begin
                            dp_active_q <= 1'b1;
                            dp_write_q  <= HWRITE;
                            dp_idx_q    <= acc_idx;
                            dp_be_q     <= acc_be;
                            if (acc_wait != 4'd0) begin
                                state_q     <= SRAM_WAIT;
                                hreadyout_q <= 1'b0;
                                wait_cnt_q  <= acc_wait;
                            end
                        end
                    end
                end
            endcase
        end
    end

    // A write commits on the edge its data phase completes
    assign mem_we  = dp_active_q & dp_write_q & hreadyout_q;
    assign rd_en   = accept & ~acc_err & ~HWRITE;
    assign fwd_hit = mem_we & (acc_idx == dp_idx_q);

    ahb_sram_byte_mem #(
        .MEM_DEPTH (MEM_DEPTH),
        .AW        (AW)
    ) u_mem (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .we      (mem_we),
        .be      (dp_be_q),
        .waddr   (dp_idx_q),
        .wdata   (HWDATA),
        .re      (rd_en),
        .raddr   (acc_idx),
        .rdata   (mem_rdata)
    );

    // Remember which lanes of the read word are superseded by a same-edge write
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            fwd_be_q   <= 4'b0000;
            fwd_data_q <= 32'h0000_0000;
        end else if (rd_en) begin
            fwd_be_q   <= fwd_hit ? dp_be_q : 4'b0000;
            fwd_data_q <= HWDATA;
        end
    end

    // Merge forwarded lanes over the stored word
    always_comb begin
        rd_word = mem_rdata;
        for (int i = 0; i < 4; i++) begin
            if (fwd_be_q[i]) begin
                rd_word[8*i +: 8] = fwd_data_q[8*i +: 8];
            end
        end
    end

    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;
    assign HRDATA    = rd_word;

endmodule
